// File: rtl/txn_seq_pkg.sv
// Shared types and constants for the transaction sequencer.
package txn_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TRAVEL = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StTravel = ST_TRAVEL,
    StStep   = ST_STEP,
    StDone   = ST_DONE,
    StError  = ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;

  // Stage codes are index+1 with 0 meaning "none".
  function automatic int unsigned code_width(input int unsigned num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/next_stage_finder.sv
// Priority search for the lowest set mask bit above idx (or anywhere when from_start).
module next_stage_finder #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CODE_W     = 3
) (
  input  logic [NUM_STAGES-1:0] mask,
  input  logic [CODE_W-1:0]     idx,
  input  logic                  from_start,
  output logic                  found,
  output logic [CODE_W-1:0]     next_idx
);

  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!found && mask[i] && (from_start || i > 32'(idx))) begin
        found    = 1'b1;
        next_idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/transaction_sequencer.sv
// Sequences a transaction through masked travel/step stages with watchdog,
// abort and completion/error reporting.
module transaction_sequencer
  import txn_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned CODE_W         = code_width(NUM_STAGES),
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start_transaction,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic                  abort,
  input  logic                  done_travel,
  input  logic                  done_step,
  output logic [CODE_W-1:0]     step,
  output logic [CODE_W-1:0]     travel,
  output logic                  busy,
  output logic                  txn_done,
  output logic                  txn_error,
  output logic [1:0]            err_code,
  output logic [CODE_W-1:0]     err_stage
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CODE_W-1:0]     idx_q, idx_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [CODE_W-1:0]     err_stage_q, err_stage_d;

  logic                  in_idle;
  logic                  found;
  logic [CODE_W-1:0]     next_idx;
  logic [CODE_W-1:0]     stage_code;
  logic                  phase_done;

  assign in_idle    = (state_q == StIdle);
  assign stage_code = idx_q + CODE_W'(1);
  assign phase_done = (state_q == StTravel) ? done_travel : done_step;

  // In IDLE the search runs on the live mask to pick the first enabled stage.
  next_stage_finder #(
    .NUM_STAGES(NUM_STAGES),
    .CODE_W    (CODE_W)
  ) u_finder (
    .mask      (in_idle ? stage_mask : mask_q),
    .idx       (idx_q),
    .from_start(in_idle),
    .found     (found),
    .next_idx  (next_idx)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      mask_q      <= '0;
      tcnt_q      <= '0;
      err_code_q  <= ERR_NONE;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      tcnt_q      <= tcnt_d;
      err_code_q  <= err_code_d;
      err_stage_q <= err_stage_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    tcnt_d      = tcnt_q;
    err_code_d  = err_code_q;
    err_stage_d = err_stage_q;
    case (state_q)
      StIdle: begin
        if (start_transaction) begin
          mask_d      = stage_mask;
          err_code_d  = ERR_NONE;
          err_stage_d = '0;
          tcnt_d      = '0;
          if (found) begin
            state_d = StTravel;
            idx_d   = next_idx;
          end else begin
            state_d = StDone;
          end
        end
      end
      StTravel, StStep: begin
        if (abort) begin
          state_d     = StError;
          err_code_d  = ERR_ABORT;
          err_stage_d = stage_code;
          tcnt_d      = '0;
        end else if (phase_done) begin
          tcnt_d = '0;
          if (state_q == StTravel) begin
            state_d = StStep;
          end else if (found) begin
            state_d = StTravel;
            idx_d   = next_idx;
          end else begin
            state_d = StDone;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          state_d     = StError;
          err_code_d  = ERR_TIMEOUT;
          err_stage_d = stage_code;
          tcnt_d      = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      StDone, StError: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  assign busy      = (state_q == StTravel) || (state_q == StStep);
  assign step      = busy ? stage_code : '0;
  assign travel    = (state_q == StTravel) ? stage_code : '0;
  assign txn_done  = (state_q == StDone);
  assign txn_error = (state_q == StError);
  assign err_code  = err_code_q;
  assign err_stage = err_stage_q;

endmodule

// File: tb/tb_transaction_sequencer.sv
// Directed bench: builds an expected per-cycle output trace from stage/phase
// durations and compares the sequencer against it every cycle.
module tb_transaction_sequencer;

  localparam int T = 8;

  logic       clock = 1'b1;
  logic       resetn, start_transaction, abort, done_travel, done_step;
  logic [3:0] stage_mask;
  logic [2:0] step, travel, err_stage;
  logic       busy, txn_done, txn_error;
  logic [1:0] err_code;

  transaction_sequencer #(
    .NUM_STAGES    (4),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .start_transaction(start_transaction),
    .stage_mask       (stage_mask),
    .abort            (abort),
    .done_travel      (done_travel),
    .done_step        (done_step),
    .step             (step),
    .travel           (travel),
    .busy             (busy),
    .txn_done         (txn_done),
    .txn_error        (txn_error),
    .err_code         (err_code),
    .err_stage        (err_stage)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rstn;
    logic       start;
    logic [3:0] mask;
    logic       abort;
    logic       dt;
    logic       ds;
  } in_t;

  typedef struct packed {
    logic [2:0] step;
    logic [2:0] travel;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] ec;
    logic [2:0] es;
  } out_t;

  in_t  in_q[$];
  out_t exp_q[$];
  in_t  cur_in;
  logic [1:0] held_ec;
  logic [2:0] held_es;

  int   checks = 0, errors = 0, n_done = 0, n_err = 0;
  out_t exp_cur, act;
  logic exp_valid = 1'b0;

  function automatic in_t quiet();
    in_t v;
    v = '0;
    v.rstn = 1'b1;
    return v;
  endfunction

  function automatic out_t idle_o();
    out_t o;
    o = '0;
    o.ec = held_ec;
    o.es = held_es;
    return o;
  endfunction

  function automatic out_t busy_o(input int s, input int p);
    out_t o;
    o = idle_o();
    o.step   = 3'(s + 1);
    o.travel = (p == 0) ? 3'(s + 1) : 3'd0;
    o.busy   = 1'b1;
    return o;
  endfunction

  // cur_in is the input vector applied at the edge that produces o.
  task automatic push(input out_t o);
    in_q.push_back(cur_in);
    exp_q.push_back(o);
    cur_in = quiet();
  endtask

  task automatic plan_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cur_in.rstn = 1'b0;
      held_ec = 2'b00;
      held_es = 3'd0;
      push('0);
    end
  endtask

  task automatic plan_idle(input int n, input logic ab);
    for (int i = 0; i < n; i++) begin
      push(idle_o());
      cur_in.abort = ab;
    end
  endtask

  // Every phase lasts dly cycles (done on its last cycle) except phase
  // (sp_stage, sp_phase), which lasts sp_len and ends per sp_kind:
  // 0 normal (timeout if sp_len > T), 1 abort together with done, 2 reset.
  task automatic plan_txn(input logic [3:0] mask, input int dly, input logic noisy,
                          input int sp_stage, input int sp_phase, input int sp_len,
                          input int sp_kind);
    out_t o;
    int   len, lim;
    logic sp;
    push(idle_o());
    cur_in.start = 1'b1;
    cur_in.mask  = mask;
    held_ec = 2'b00;
    held_es = 3'd0;
    for (int s = 0; s < 4; s++) begin
      if (mask[s]) begin
        for (int p = 0; p < 2; p++) begin
          sp  = (s == sp_stage) && (p == sp_phase);
          len = sp ? sp_len : dly;
          lim = (len > T) ? T : len;
          for (int c = 1; c <= lim; c++) begin
            push(busy_o(s, p));
            if (noisy) begin
              cur_in.start = 1'b1;
              cur_in.mask  = 4'($urandom);
              if (p == 0) cur_in.ds = 1'b1;
              else        cur_in.dt = 1'b1;
            end
            if (c == len) begin
              if (p == 0) cur_in.dt = 1'b1;
              else        cur_in.ds = 1'b1;
              if (sp && sp_kind == 1) cur_in.abort = 1'b1;
              if (sp && sp_kind == 2) begin
                cur_in = quiet();
                cur_in.rstn = 1'b0;
              end
            end
          end
          if (sp && sp_kind == 2) begin
            held_ec = 2'b00;
            held_es = 3'd0;
            push('0);
            return;
          end
          if ((sp && sp_kind == 1) || len > T) begin
            held_ec = (sp && sp_kind == 1) ? 2'b10 : 2'b01;
            held_es = 3'(s + 1);
            o = idle_o();
            o.err = 1'b1;
            push(o);
            if (noisy) cur_in.start = 1'b1;
            return;
          end
        end
      end
    end
    o = idle_o();
    o.done = 1'b1;
    push(o);
    if (noisy) cur_in.start = 1'b1;
  endtask

  task automatic check_lit(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, a, e);
    end
  endtask

  task automatic apply(input in_t v);
    resetn            = v.rstn;
    start_transaction = v.start;
    stage_mask        = v.mask;
    abort             = v.abort;
    done_travel       = v.dt;
    done_step         = v.ds;
  endtask

  always @(negedge clock) begin
    if (exp_valid) begin
      act = {step, travel, busy, txn_done, txn_error, err_code, err_stage};
      checks++;
      if (act !== exp_cur) begin
        errors++;
        $display("FAIL trace t=%0t: got step=%0d travel=%0d busy=%b done=%b err=%b ec=%b es=%0d, expected step=%0d travel=%0d busy=%b done=%b err=%b ec=%b es=%0d",
                 $time, act.step, act.travel, act.busy, act.done, act.err, act.ec, act.es,
                 exp_cur.step, exp_cur.travel, exp_cur.busy, exp_cur.done, exp_cur.err,
                 exp_cur.ec, exp_cur.es);
      end
      if (txn_done === 1'b1) n_done++;
      if (txn_error === 1'b1) n_err++;
    end
  end

  initial begin
    int s0;
    apply(quiet());
    resetn  = 1'b0;
    cur_in  = quiet();
    held_ec = 2'b00;
    held_es = 3'd0;

    plan_reset(2);
    plan_idle(2, 1'b1);
    s0 = exp_q.size();
    plan_txn(4'b1111, 3, 1'b0, -1, 0, 0, 0);
    check_lit("plan_all_stages_len", exp_q.size() - s0, 26);
    s0 = exp_q.size();
    plan_txn(4'b1010, 3, 1'b1, -1, 0, 0, 0);
    check_lit("plan_skip_mask_len", exp_q.size() - s0, 14);
    s0 = exp_q.size();
    plan_txn(4'b0000, 1, 1'b0, -1, 0, 0, 0);
    check_lit("plan_zero_mask_len", exp_q.size() - s0, 2);
    s0 = exp_q.size();
    plan_txn(4'b1111, 1, 1'b0, 2, 1, 20, 0);
    check_lit("plan_timeout_len", exp_q.size() - s0, 15);
    check_lit("plan_timeout_code", int'(held_ec), 1);
    plan_idle(2, 1'b0);
    plan_txn(4'b1111, 1, 1'b0, 2, 1, T, 0);
    plan_txn(4'b1111, 2, 1'b1, 1, 0, 2, 1);
    check_lit("plan_abort_stage", int'(held_es), 2);
    plan_idle(1, 1'b0);
    plan_txn(4'b0001, 1, 1'b0, -1, 0, 0, 0);
    plan_txn(4'b1111, 2, 1'b0, 1, 1, 1, 2);
    plan_txn(4'b1000, 2, 1'b0, -1, 0, 0, 0);
    plan_idle(2, 1'b0);

    for (int k = 0; k < in_q.size(); k++) begin
      @(negedge clock);
      apply(in_q[k]);
      @(posedge clock);
      #1;
      exp_cur   = exp_q[k];
      exp_valid = 1'b1;
    end
    @(negedge clock);
    #1;
    exp_valid = 1'b0;

    check_lit("done_pulses", n_done, 6);
    check_lit("error_pulses", n_err, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
